// File: rtl/player_bullet_controller.sv
// Player bullet pool: eight slots that spawn at the ship on fire, rise by
// SPEED pixels every MOVE_DIV cycles, and retire on a hit report or when
// they would pass the top of the screen. All outputs come straight from
// registers.
module player_bullet_controller #(
  parameter int MOVE_DIV        = 100_000,
  parameter int SPEED           = 4,
  parameter int COOLDOWN_CYCLES = 2_500_000,
  parameter int SPAWN_X_OFFSET  = 12,
  parameter int BULLET_H        = 8
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        fire,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [7:0]  hit_flat,
  output logic [79:0] bullet_x_flat,
  output logic [79:0] bullet_y_flat,
  output logic [7:0]  bullet_active_flat,
  output logic [7:0]  shots_fired
);

  localparam logic [16:0] MOVE_LAST = 17'(MOVE_DIV - 1);
  localparam logic [21:0] CD_LOAD   = 22'(COOLDOWN_CYCLES - 1);
  localparam logic [9:0]  SPEED_V   = 10'(SPEED);
  localparam logic [9:0]  X_OFF     = 10'(SPAWN_X_OFFSET);
  localparam logic [9:0]  H_V       = 10'(BULLET_H);

  logic [7:0]  active;
  logic [9:0]  x_q [8];
  logic [9:0]  y_q [8];
  logic [16:0] move_counter;
  logic [21:0] cooldown;

  logic [7:0]  active_n;
  logic [9:0]  x_n [8];
  logic [9:0]  y_n [8];
  logic [16:0] move_counter_n;
  logic [21:0] cooldown_n;
  logic [7:0]  shots_n;
  logic        tick;
  logic        any_free;
  logic [2:0]  free_idx;
  logic        spawn;

  // Spawn row sits BULLET_H above the ship top, clamped to the screen edge.
  function automatic logic [9:0] spawn_row(input logic [9:0] py);
    return (py < H_V) ? 10'd0 : py - H_V;
  endfunction

  // Spawn column wraps within the 10-bit coordinate space.
  function automatic logic [9:0] spawn_col(input logic [9:0] px);
    return px + X_OFF;
  endfunction

  // Lowest-index free slot, judged on the state at the start of the cycle
  // so slots retired this cycle only become eligible next cycle.
  always_comb begin
    any_free = 1'b0;
    free_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!active[i]) begin
        any_free = 1'b1;
        free_idx = 3'(i);
      end
    end
  end

  // Next-state: hit beats move, spawn fills a slot that was idle anyway.
  always_comb begin
    tick           = (move_counter == MOVE_LAST);
    spawn          = fire && (cooldown == 22'd0) && any_free;
    move_counter_n = tick ? 17'd0 : move_counter + 17'd1;
    shots_n        = spawn ? shots_fired + 8'd1 : shots_fired;
    if (spawn)
      cooldown_n = CD_LOAD;
    else if (cooldown != 22'd0)
      cooldown_n = cooldown - 22'd1;
    else
      cooldown_n = cooldown;
    active_n = active;
    for (int i = 0; i < 8; i++) begin
      x_n[i] = x_q[i];
      y_n[i] = y_q[i];
      if (active[i] && hit_flat[i]) begin
        active_n[i] = 1'b0;
      end else if (active[i] && tick) begin
        if (y_q[i] < SPEED_V)
          active_n[i] = 1'b0;
        else
          y_n[i] = y_q[i] - SPEED_V;
      end
      if (spawn && (free_idx == 3'(i))) begin
        active_n[i] = 1'b1;
        x_n[i]      = spawn_col(player_x);
        y_n[i]      = spawn_row(player_y);
      end
    end
  end

  // State register; reset clears the whole pool including coordinates.
  always_ff @(posedge clk25) begin
    if (rst) begin
      active       <= '0;
      move_counter <= '0;
      cooldown     <= '0;
      shots_fired  <= '0;
      for (int i = 0; i < 8; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      active       <= active_n;
      move_counter <= move_counter_n;
      cooldown     <= cooldown_n;
      shots_fired  <= shots_n;
      for (int i = 0; i < 8; i++) begin
        x_q[i] <= x_n[i];
        y_q[i] <= y_n[i];
      end
    end
  end

  // Flatten slot registers onto the consumer buses.
  always_comb begin
    bullet_x_flat      = '0;
    bullet_y_flat      = '0;
    bullet_active_flat = active;
    for (int i = 0; i < 8; i++) begin
      bullet_x_flat[i*10 +: 10] = x_q[i];
      bullet_y_flat[i*10 +: 10] = y_q[i];
    end
  end

endmodule

// File: tb/tb_player_bullet_controller.sv
// Directed bench for player_bullet_controller with short timing parameters.
module tb_player_bullet_controller;

  logic        clk25 = 1'b0;
  logic        rst = 1'b1;
  logic        fire = 1'b0;
  logic [9:0]  player_x = 10'd100;
  logic [9:0]  player_y = 10'd400;
  logic [7:0]  hit_flat = 8'd0;
  logic [79:0] bullet_x_flat;
  logic [79:0] bullet_y_flat;
  logic [7:0]  bullet_active_flat;
  logic [7:0]  shots_fired;

  int total = 0;
  int bad   = 0;

  player_bullet_controller #(
    .MOVE_DIV(4), .SPEED(4), .COOLDOWN_CYCLES(6),
    .SPAWN_X_OFFSET(12), .BULLET_H(8)
  ) dut (
    .clk25(clk25), .rst(rst), .fire(fire),
    .player_x(player_x), .player_y(player_y), .hit_flat(hit_flat),
    .bullet_x_flat(bullet_x_flat), .bullet_y_flat(bullet_y_flat),
    .bullet_active_flat(bullet_active_flat), .shots_fired(shots_fired)
  );

  always #5 clk25 = ~clk25;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk25);
    #1;
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] bx(input int i);
    return bullet_x_flat[i*10 +: 10];
  endfunction

  function automatic logic [9:0] by(input int i);
    return bullet_y_flat[i*10 +: 10];
  endfunction

  initial begin
    int cnt;
    logic [7:0] exp_act;

    // reset for two edges
    step(); step();
    check("rst_active", bullet_active_flat, 8'h00);
    check("rst_shots", shots_fired, 8'd0);
    check("rst_x", bullet_x_flat, 80'd0);
    check("rst_y", bullet_y_flat, 80'd0);

    // single fire pulse
    rst = 1'b0; fire = 1'b1;
    step();
    fire = 1'b0;
    check("spawn_active", bullet_active_flat, 8'h01);
    check("spawn_x0", bx(0), 10'd112);
    check("spawn_y0", by(0), 10'd392);
    check("spawn_shots", shots_fired, 8'd1);

    // movement: tick on the 4th edge after reset, then every 4
    step(); step();
    check("move_pre_tick", by(0), 10'd392);
    step();
    check("move_tick1", by(0), 10'd388);
    step(); step(); step(); step();
    check("move_tick2", by(0), 10'd384);
    check("move_x", bx(0), 10'd112);

    // cooldown and fill from a clean reset
    rst = 1'b1; step(); rst = 1'b0;
    check("rst2_active", bullet_active_flat, 8'h00);
    fire = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      cnt = ((k - 1) / 6) + 1;
      if (cnt > 8) cnt = 8;
      exp_act = 8'((1 << cnt) - 1);
      check("fill_active", bullet_active_flat, exp_act);
      check("fill_shots", shots_fired, 8'(cnt));
    end

    // hit on slot2 while full, then refill at new position
    hit_flat = 8'b0000_0100;
    step();
    hit_flat = 8'd0;
    check("hit_active", bullet_active_flat, 8'hFB);
    check("hit_shots", shots_fired, 8'd8);
    player_x = 10'd200; player_y = 10'd300;
    step();
    check("refill_active", bullet_active_flat, 8'hFF);
    check("refill_shots", shots_fired, 8'd9);
    check("refill_x2", bx(2), 10'd212);
    check("refill_y2", by(2), 10'd292);

    // hit on an already inactive slot is ignored
    fire = 1'b0;
    hit_flat = 8'h01;
    step();
    check("hit0_active", bullet_active_flat, 8'hFE);
    step();
    hit_flat = 8'd0;
    check("hit_inactive", bullet_active_flat, 8'hFE);
    check("hit_inactive_x0", bx(0), 10'd112);
    check("hit_inactive_shots", shots_fired, 8'd9);

    // saturated spawn at y=0, retired at first tick
    rst = 1'b1; step(); rst = 1'b0;
    player_x = 10'd100; player_y = 10'd5; fire = 1'b1;
    step();
    fire = 1'b0;
    check("sat_y0", by(0), 10'd0);
    check("sat_active", bullet_active_flat, 8'h01);
    step(); step();
    check("sat_before_tick", bullet_active_flat, 8'h01);
    step();
    check("sat_retired", bullet_active_flat, 8'h00);
    check("sat_y_hold", by(0), 10'd0);
    check("sat_x_hold", bx(0), 10'd112);

    // spawn y=6: moves to 2, then retires
    player_y = 10'd14; fire = 1'b1;
    step(); step();
    check("cd_block", bullet_active_flat, 8'h00);
    step();
    fire = 1'b0;
    check("y6_active", bullet_active_flat, 8'h01);
    check("y6_y0", by(0), 10'd6);
    check("y6_shots", shots_fired, 8'd2);
    step();
    check("y6_tick1", by(0), 10'd2);
    check("y6_still_active", bullet_active_flat, 8'h01);
    step(); step(); step(); step();
    check("y6_retired", bullet_active_flat, 8'h00);
    check("y6_y_hold", by(0), 10'd2);

    // reset mid-flight with cooldown pending
    rst = 1'b1; step(); rst = 1'b0;
    player_y = 10'd400; fire = 1'b1;
    for (int k = 0; k < 13; k++) step();
    check("mid_active", bullet_active_flat, 8'h07);
    check("mid_shots", shots_fired, 8'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_active", bullet_active_flat, 8'h00);
    check("midrst_shots", shots_fired, 8'd0);
    check("midrst_x", bullet_x_flat, 80'd0);
    check("midrst_y", bullet_y_flat, 80'd0);
    step();
    fire = 1'b0;
    check("post_rst_active", bullet_active_flat, 8'h01);
    check("post_rst_shots", shots_fired, 8'd1);
    check("post_rst_x0", bx(0), 10'd112);
    check("post_rst_y0", by(0), 10'd392);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
